mdio_phy_target: RTL

PHY-side management target that sits directly downstream of the MDIO controller. It decodes the serial frames that the controller shifts out on MDC/MDIO_OUT, which carry the same 32-bit T_DATA frame format. It holds a 32 x 16-bit Clause-22 style register file and answers read frames by driving MDIO_IN back to the controller. It also exposes a write strobe so that PHY-model logic can observe register updates.

---
 rtl/mdio_phy_target_if.sv | 31 +++
 rtl/mdio_phy_target.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_target_if.sv
// rtl/mdio_phy_target_if.sv - MDIO bus and write-observation signals between controller and PHY target
//
// Signals:
//   MDC      controller -> target  management clock, sampled as data
//   MDIO_OE  controller -> target  high while the controller owns the bus
//   MDIO_OUT controller -> target  serial frame data
//   MDIO_IN  target -> controller  serial read data (idles high)
//   MDIO_DRV target -> controller  high while the target drives MDIO_IN
//   WR_STB   target -> observer    one-CLK pulse per performed register write
//   WR_ADDR  target -> observer    register address of the last write
//   WR_DATA  target -> observer    data of the last write
interface mdio_phy_target_if;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic        MDIO_IN;
    logic        MDIO_DRV;
    logic        WR_STB;
    logic [4:0]  WR_ADDR;
    logic [15:0] WR_DATA;

    modport master (
        output MDC, MDIO_OE, MDIO_OUT,
        input  MDIO_IN, MDIO_DRV, WR_STB, WR_ADDR, WR_DATA
    );

    modport slave (
        input  MDC, MDIO_OE, MDIO_OUT,
        output MDIO_IN, MDIO_DRV, WR_STB, WR_ADDR, WR_DATA
    );
endinterface

// File: rtl/mdio_phy_target.sv
// rtl/mdio_phy_target.sv - Clause-22 style MDIO PHY management target with 32 x 16-bit register file
//
// Ports:
//   CLK    system clock (MDC is generated from it and is treated as data)
//   RESET  asynchronous active-low reset
//   bus    mdio_phy_target_if.slave: MDC/MDIO_OE/MDIO_OUT in, MDIO_IN/MDIO_DRV out,
//          WR_STB/WR_ADDR/WR_DATA write observation outputs
module mdio_phy_target #(
    parameter logic [4:0]  PHY_ADDR  = 5'd1,
    parameter logic [15:0] PHY_ID_HI = 16'h0022,
    parameter logic [15:0] PHY_ID_LO = 16'h1560
) (
    input  logic             CLK,
    input  logic             RESET,
    mdio_phy_target_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic        mdc_q;
    logic [3:0]  cnt_q, cnt_d;
    // Second-phase flag: TA(read) = first fall seen, RDATA = all 16 bits sent,
    // DISCARD = the two TA slots are consumed and the 16 data slots follow.
    logic        phase_q, phase_d;
    logic [11:0] hdr_q, hdr_d;          // {OP, PHYAD, REGAD}
    logic [15:0] sh_q, sh_d;            // write data in / read data out
    logic        mdio_in_q, mdio_in_d;
    logic        mdio_drv_q, mdio_drv_d;
    logic        wr_stb_q, wr_stb_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] regs_q [32];

    logic        rise, fall, wr_en;
    logic [11:0] hdr_shift;
    logic [15:0] sh_shift;
    logic [15:0] rd_word;

    assign rise      = bus.MDC & ~mdc_q;
    assign fall      = ~bus.MDC & mdc_q;
    assign hdr_shift = {hdr_q[10:0], bus.MDIO_OUT};
    assign sh_shift  = {sh_q[14:0], bus.MDIO_OUT};

    // Read source for the register address completed by the current REGAD bit.
    always_comb begin
        case (hdr_shift[4:0])
            5'd2:    rd_word = PHY_ID_HI;
            5'd3:    rd_word = PHY_ID_LO;
            default: rd_word = regs_q[hdr_shift[4:0]];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        hdr_d      = hdr_q;
        sh_d       = sh_q;
        mdio_in_d  = mdio_in_q;
        mdio_drv_d = mdio_drv_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en      = 1'b0;

        if (rise && !bus.MDIO_OE &&
            state_q != S_IDLE && state_q != S_DISCARD && state_q != S_RDATA) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise && bus.MDIO_OE && !bus.MDIO_OUT) state_d = S_ST1;
                end
                S_ST1: begin
                    if (rise) begin
                        state_d = bus.MDIO_OUT ? S_OP : S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                S_OP: begin
                    if (rise) begin
                        hdr_d = hdr_shift;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = S_PHYAD;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                S_PHYAD: begin
                    if (rise) begin
                        hdr_d = hdr_shift;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd4) begin
                            state_d = S_REGAD;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                S_REGAD: begin
                    if (rise) begin
                        hdr_d = hdr_shift;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd4) begin
                            cnt_d   = 4'd0;
                            phase_d = 1'b0;
                            if ((hdr_shift[11:10] != 2'b01 && hdr_shift[11:10] != 2'b10) ||
                                hdr_shift[9:5] != PHY_ADDR) begin
                                state_d = S_DISCARD;
                            end else begin
                                state_d = S_TA;
                                sh_d    = rd_word;
                            end
                        end
                    end
                end
                S_TA: begin
                    if (hdr_q[11:10] == 2'b01) begin
                        if (rise) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q == 4'd1) begin
                                state_d = S_WDATA;
                                cnt_d   = 4'd0;
                            end
                        end
                    end else if (fall) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            mdio_drv_d = 1'b1;
                            mdio_in_d  = 1'b0;
                            state_d    = S_RDATA;
                            cnt_d      = 4'd0;
                            phase_d    = 1'b0;
                        end
                    end
                end
                S_WDATA: begin
                    if (rise) begin
                        sh_d  = sh_shift;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_d = S_IDLE;
                            if (hdr_q[4:0] != 5'd2 && hdr_q[4:0] != 5'd3) begin
                                wr_en     = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = hdr_q[4:0];
                                wr_data_d = sh_shift;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (fall) begin
                        if (phase_q) begin
                            mdio_drv_d = 1'b0;
                            mdio_in_d  = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            mdio_in_d = sh_q[15];
                            sh_d      = {sh_q[14:0], 1'b0};
                            cnt_d     = cnt_q + 4'd1;
                            if (cnt_q == 4'd15) phase_d = 1'b1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (rise) begin
                        cnt_d = cnt_q + 4'd1;
                        if (!phase_q) begin
                            if (cnt_q == 4'd1) begin
                                phase_d = 1'b1;
                                cnt_d   = 4'd0;
                            end
                        end else if (cnt_q == 4'd15) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            mdc_q      <= 1'b0;
            cnt_q      <= 4'd0;
            phase_q    <= 1'b0;
            hdr_q      <= 12'd0;
            sh_q       <= 16'd0;
            mdio_in_q  <= 1'b1;
            mdio_drv_q <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            mdc_q      <= bus.MDC;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            hdr_q      <= hdr_d;
            sh_q       <= sh_d;
            mdio_in_q  <= mdio_in_d;
            mdio_drv_q <= mdio_drv_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Entries 2 and 3 are never written; reads of them come from the ID constants.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 16'd0;
        end else if (wr_en) begin
            regs_q[hdr_q[4:0]] <= sh_shift;
        end
    end

    assign bus.MDIO_IN  = mdio_in_q;
    assign bus.MDIO_DRV = mdio_drv_q;
    assign bus.WR_STB   = wr_stb_q;
    assign bus.WR_ADDR  = wr_addr_q;
    assign bus.WR_DATA  = wr_data_q;
endmodule
